mac_out_serializer: RTL and testbench

- Downstream stage of the MAC lane array. Captures one result vector per cycle from VEC_S lock-stepped MAC lanes, i.e. their f/valid_out/overflow outputs.
- Per lane: saturates results flagged as overflowed, then optionally applies ReLU.
- Buffers up to DEPTH vectors and serializes the elements, lane 0 first, onto a single 16-bit valid/ready stream for the next layer or the host.
- The MAC lanes have no backpressure, so a vector arriving while the buffer is full is dropped and flagged.

---
 rtl/defines_pkg.sv | 14 +
 rtl/mac_sat_relu.sv | 26 ++
 rtl/mac_out_serializer.sv | 126 ++++++++++++
 tb/tb_mac_out_serializer.sv | 222 ++++++++++++++++++++++
 4 files changed

// File: rtl/defines_pkg.sv
// Shared widths, types and constants for the MAC datapath and its output stages.
package defines_pkg;

    localparam int ACC_W = 16;

    typedef logic signed [ACC_W-1:0] acc_t;

    localparam acc_t ACC_MAX = 16'h7FFF;
    localparam acc_t ACC_MIN = 16'h8000;

    // Number of lock-stepped MAC lanes in the default array configuration.
    localparam int DEF_VEC_S = 4;

endpackage

// File: rtl/mac_sat_relu.sv
// Per-lane result conditioning: saturate wrapped accumulator results, then optional ReLU.
module mac_sat_relu
    import defines_pkg::*;
#(
    parameter int RELU = 1
) (
    input  acc_t f,
    input  logic ovf,
    output acc_t res
);

    acc_t w_sat;

    // Saturate toward the true sign: a wrapped negative means the true result was positive.
    always_comb begin
        w_sat = f;
        if (ovf) begin
            w_sat = f[ACC_W-1] ? ACC_MAX : ACC_MIN;
        end
        res = w_sat;
        if ((RELU != 0) && w_sat[ACC_W-1]) begin
            res = '0;
        end
    end

endmodule

// File: rtl/mac_out_serializer.sv
// Buffers whole result vectors from the MAC lanes and streams their elements, lane 0 first,
// onto a single valid/ready channel. Vectors arriving with no free slot are dropped.
module mac_out_serializer
    import defines_pkg::*;
#(
    parameter int VEC_S = DEF_VEC_S,
    parameter int DEPTH = 2,
    parameter int RELU  = 1
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic [VEC_S*ACC_W-1:0]      f_in,
    input  logic                        valid_in,
    input  logic [VEC_S-1:0]            ovf_in,
    output logic [ACC_W-1:0]            z,
    output logic                        z_valid,
    input  logic                        z_ready,
    output logic [$clog2(VEC_S)-1:0]    z_idx,
    output logic                        z_last,
    output logic                        full,
    output logic                        drop_err,
    input  logic                        err_clr
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam int IDX_W = $clog2(VEC_S);

    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DEPTH);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(VEC_S - 1);

    acc_t             w_conv [VEC_S];
    acc_t             r_mem  [DEPTH][VEC_S];
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [CNT_W-1:0] r_count;
    logic [CNT_W-1:0] w_count_nxt;
    logic [IDX_W-1:0] r_elem_cnt;
    logic             r_full;
    logic             r_drop_err;
    logic             w_xfer;
    logic             w_last;
    logic             w_pop;
    logic             w_push;
    logic             w_drop;

    for (genvar gi = 0; gi < VEC_S; gi++) begin : g_lane
        mac_sat_relu #(
            .RELU (RELU)
        ) u_sat (
            .f   (f_in[gi*ACC_W +: ACC_W]),
            .ovf (ovf_in[gi]),
            .res (w_conv[gi])
        );
    end

    // Handshake, slot pop/push decisions and next occupancy.
    always_comb begin
        w_xfer      = z_valid && z_ready;
        w_last      = (r_elem_cnt == IDX_LAST);
        w_pop       = w_xfer && w_last;
        // A pop frees the head slot at the same edge, so a full buffer can still accept.
        w_push      = valid_in && ((r_count != CNT_FULL) || w_pop);
        w_drop      = valid_in && !w_push;
        w_count_nxt = r_count;
        if (w_push && !w_pop) begin
            w_count_nxt = r_count + 1'b1;
        end else if (w_pop && !w_push) begin
            w_count_nxt = r_count - 1'b1;
        end
    end

    // Vector storage; contents need no reset since occupancy gates every read.
    always_ff @(posedge clk) begin
        if (w_push) begin
            for (int i = 0; i < VEC_S; i++) begin
                r_mem[r_wr_ptr][i] <= w_conv[i];
            end
        end
    end

    // Pointers, occupancy, element counter and sticky drop flag.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_count    <= '0;
            r_full     <= 1'b0;
            r_elem_cnt <= '0;
            r_drop_err <= 1'b0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            r_count <= w_count_nxt;
            r_full  <= (w_count_nxt == CNT_FULL);
            if (w_xfer) begin
                r_elem_cnt <= w_last ? '0 : r_elem_cnt + 1'b1;
            end
            // A drop in the same cycle as a clear must still be reported.
            if (w_drop) begin
                r_drop_err <= 1'b1;
            end else if (err_clr) begin
                r_drop_err <= 1'b0;
            end
        end
    end

    // Output element is forced to zero when nothing is buffered.
    always_comb begin
        z = '0;
        if (z_valid) begin
            z = r_mem[r_rd_ptr][r_elem_cnt];
        end
    end

    assign z_valid  = (r_count != '0);
    assign z_idx    = r_elem_cnt;
    assign z_last   = (r_elem_cnt == IDX_LAST);
    assign full     = r_full;
    assign drop_err = r_drop_err;

endmodule

// File: tb/tb_mac_out_serializer.sv
// Randomized self-checking bench for mac_out_serializer; runs RELU=0 and RELU=1 instances
// side by side on shared stimulus against an element-queue reference model.
module tb_mac_out_serializer;

    localparam int VEC_S = 4;
    localparam int DEPTH = 2;
    localparam int IDX_W = 2;

    logic                clk = 1'b0;
    logic                reset = 1'b0;
    logic [VEC_S*16-1:0] f_in = '0;
    logic                valid_in = 1'b0;
    logic [VEC_S-1:0]    ovf_in = '0;
    logic                z_ready = 1'b0;
    logic                err_clr = 1'b0;

    logic [15:0]      z0, z1;
    logic             zv0, zv1, zl0, zl1, full0, full1, derr0, derr1;
    logic [IDX_W-1:0] zi0, zi1;

    int n_chk  = 0;
    int n_fail = 0;

    // Model: flat queues of pending elements, one per RELU setting.
    logic [15:0] q0[$];
    logic [15:0] q1[$];
    logic        m_err = 1'b0;

    always #5 clk = ~clk;

    mac_out_serializer #(.VEC_S(VEC_S), .DEPTH(DEPTH), .RELU(0)) u_dut0 (
        .clk(clk), .reset(reset), .f_in(f_in), .valid_in(valid_in), .ovf_in(ovf_in),
        .z(z0), .z_valid(zv0), .z_ready(z_ready), .z_idx(zi0), .z_last(zl0),
        .full(full0), .drop_err(derr0), .err_clr(err_clr)
    );

    mac_out_serializer #(.VEC_S(VEC_S), .DEPTH(DEPTH), .RELU(1)) u_dut1 (
        .clk(clk), .reset(reset), .f_in(f_in), .valid_in(valid_in), .ovf_in(ovf_in),
        .z(z1), .z_valid(zv1), .z_ready(z_ready), .z_idx(zi1), .z_last(zl1),
        .full(full1), .drop_err(derr1), .err_clr(err_clr)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Exact value of the lane result, clamped to 16-bit signed, then optional ReLU.
    function automatic logic [15:0] conv(input logic [15:0] f, input logic ovf, input int relu);
        int v;
        v = int'($signed(f));
        if (ovf) v = (v < 0) ? v + 65536 : v - 65536;
        if (v > 32767) v = 32767;
        if (v < -32768) v = -32768;
        if (relu != 0 && v < 0) v = 0;
        return v[15:0];
    endfunction

    function automatic int m_slots();
        return (q0.size() + VEC_S - 1) / VEC_S;
    endfunction

    function automatic int m_idx();
        return (VEC_S - (q0.size() % VEC_S)) % VEC_S;
    endfunction

    task automatic check_outputs();
        logic       ev;
        logic [1:0] ei;
        ev = (q0.size() != 0);
        ei = 2'(m_idx());
        chk("z_valid0", {31'b0, zv0}, {31'b0, ev});
        chk("z_valid1", {31'b0, zv1}, {31'b0, ev});
        chk("z_idx0", {30'b0, zi0}, {30'b0, ei});
        chk("z_idx1", {30'b0, zi1}, {30'b0, ei});
        chk("z_last0", {31'b0, zl0}, {31'b0, ev && (m_idx() == VEC_S - 1)});
        chk("full0", {31'b0, full0}, {31'b0, m_slots() == DEPTH});
        chk("full1", {31'b0, full1}, {31'b0, m_slots() == DEPTH});
        chk("drop_err0", {31'b0, derr0}, {31'b0, m_err});
        chk("drop_err1", {31'b0, derr1}, {31'b0, m_err});
        if (ev) begin
            chk("z0", {16'b0, z0}, {16'b0, q0[0]});
            chk("z1", {16'b0, z1}, {16'b0, q1[0]});
        end
    endtask

    task automatic model_update();
        logic xfer, accept;
        xfer   = (q0.size() != 0) && z_ready;
        accept = valid_in && ((m_slots() < DEPTH) || (xfer && m_idx() == VEC_S - 1));
        if (xfer) begin
            void'(q0.pop_front());
            void'(q1.pop_front());
        end
        if (accept) begin
            for (int i = 0; i < VEC_S; i++) begin
                q0.push_back(conv(f_in[i*16 +: 16], ovf_in[i], 0));
                q1.push_back(conv(f_in[i*16 +: 16], ovf_in[i], 1));
            end
        end
        if (valid_in && !accept) m_err = 1'b1;
        else if (err_clr) m_err = 1'b0;
    endtask

    task automatic step();
        @(negedge clk);
        check_outputs();
        @(posedge clk);
        model_update();
        #1;
    endtask

    task automatic steps(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic set_vec(input logic [15:0] e0, input logic [15:0] e1, input logic [15:0] e2,
                           input logic [15:0] e3, input logic [3:0] ovf);
        f_in   = {e3, e2, e1, e0};
        ovf_in = ovf;
    endtask

    task automatic push_one(input logic [15:0] e0, input logic [15:0] e1,
                            input logic [15:0] e2, input logic [15:0] e3, input logic [3:0] ovf);
        set_vec(e0, e1, e2, e3, ovf);
        valid_in = 1'b1;
        step();
        valid_in = 1'b0;
    endtask

    task automatic push_rand();
        push_one(16'($urandom), 16'($urandom), 16'($urandom), 16'($urandom), 4'($urandom));
    endtask

    task automatic check_all_zero(input string tag);
        chk({tag, "_z"}, {16'b0, z0 | z1}, 32'h0);
        chk({tag, "_zv"}, {30'b0, zv0, zv1}, 32'h0);
        chk({tag, "_zi"}, {28'b0, zi0, zi1}, 32'h0);
        chk({tag, "_zl"}, {30'b0, zl0, zl1}, 32'h0);
        chk({tag, "_full"}, {30'b0, full0, full1}, 32'h0);
        chk({tag, "_derr"}, {30'b0, derr0, derr1}, 32'h0);
    endtask

    initial begin
        // Power-on reset.
        #3;
        check_all_zero("reset");
        @(posedge clk);
        #1 reset = 1'b1;

        // Basic stream with pass-through values.
        z_ready = 1'b1;
        push_one(16'd100, 16'hFFFB, 16'd32752, 16'h8000, 4'b0000);
        steps(6);

        // Saturation in both directions plus ReLU of a plain negative.
        push_one(16'h8010, 16'h7FF0, 16'hFFF9, 16'd1234, 4'b0011);
        steps(6);

        // Overfill with the consumer stalled: third vector dropped, then drain and clear.
        z_ready = 1'b0;
        push_rand();
        push_rand();
        push_rand();
        steps(3);
        z_ready = 1'b1;
        steps(10);
        err_clr = 1'b1;
        step();
        err_clr = 1'b0;
        steps(2);

        // Push on the exact cycle the head vector's last element leaves a full buffer.
        z_ready = 1'b0;
        push_rand();
        push_rand();
        z_ready = 1'b1;
        steps(VEC_S - 1);
        push_rand();
        steps(2 * VEC_S + 2);

        // Random traffic with random backpressure and clears.
        for (int i = 0; i < 400; i++) begin
            set_vec(16'($urandom), 16'($urandom), 16'($urandom), 16'($urandom),
                    4'($urandom_range(0, 15) & $urandom_range(0, 15)));
            valid_in = ($urandom_range(0, 4) == 0);
            z_ready  = $urandom_range(0, 1) != 0;
            err_clr  = ($urandom_range(0, 19) == 0);
            step();
        end
        valid_in = 1'b0;
        err_clr  = 1'b0;
        z_ready  = 1'b1;
        steps(3 * VEC_S);

        // Asynchronous reset mid-stream with two vectors buffered and drop_err set.
        z_ready = 1'b0;
        push_rand();
        push_rand();
        push_rand();
        z_ready = 1'b1;
        step();
        @(negedge clk);
        #2 reset = 1'b0;
        #1;
        check_all_zero("async_rst");
        q0.delete();
        q1.delete();
        m_err = 1'b0;
        @(posedge clk);
        #1 reset = 1'b1;
        push_one(16'd7, 16'd8, 16'hFFFF, 16'd10, 4'b0000);
        steps(6);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
